// File: rtl/eth_frame_packer.sv
// eth_frame_packer: buffers sample words in a single-clock FIFO and emits
// complete Ethernet II frames (header + sequence number + payload) byte-wise
// on a local-link TX interface with src_rdy/dst_rdy handshaking.
module eth_frame_packer #(
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned FIFO_DEPTH    = 512,
    parameter int unsigned PAYLOAD_WORDS = 355,
    parameter logic [47:0] DST_MAC       = 48'hDA0203040506,
    parameter logic [47:0] SRC_MAC       = 48'h002B67BECEAA,
    parameter logic [15:0] ETHERTYPE     = 16'h0800,
    parameter int unsigned IFG_CYCLES    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [7:0]                    tx_data,
    output logic                          tx_sof,
    output logic                          tx_eof,
    output logic                          tx_src_rdy,
    input  logic                          tx_dst_rdy,
    output logic                          overflow,
    output logic [15:0]                   frame_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned LANES  = DATA_W / 8;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned WORD_W = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
    localparam int unsigned GAP_W  = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, HEAD, DATA, GAP} state_t;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              full_q, overflow_q;
    logic              push, pop;

    state_t            state_q, state_d;
    logic [3:0]        hdr_idx_q, hdr_idx_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [15:0]       seq_q, seq_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_sof_q, tx_sof_d;
    logic              tx_eof_q, tx_eof_d;
    logic              tx_src_rdy_q, tx_src_rdy_d;
    logic              start_frame;

    logic              xfer;
    logic              frame_ready;
    logic [127:0]      hdr_vec;
    logic [DATA_W-1:0] head_word, next_word;

    function automatic logic [7:0] lane_byte(input logic [DATA_W-1:0] w,
                                             input logic [LANE_W-1:0] l);
        return 8'(w >> {l, 3'b000});
    endfunction

    function automatic logic [7:0] hdr_byte(input logic [127:0] h, input logic [3:0] i);
        return 8'(h >> {4'd15 - i, 3'b000});
    endfunction

    assign push        = in_valid && !full_q;
    assign xfer        = tx_src_rdy_q && tx_dst_rdy;
    assign frame_ready = (level_q >= LVL_W'(PAYLOAD_WORDS));
    assign hdr_vec     = {DST_MAC, SRC_MAC, ETHERTYPE, seq_q};
    assign head_word   = mem[rd_ptr_q];
    assign next_word   = mem[rd_ptr_q + PTR_W'(1)];

    assign in_ready    = !full_q;
    assign overflow    = overflow_q;
    assign frame_cnt   = frame_cnt_q;
    assign fifo_level  = level_q;
    assign tx_data     = tx_data_q;
    assign tx_sof      = tx_sof_q;
    assign tx_eof      = tx_eof_q;
    assign tx_src_rdy  = tx_src_rdy_q;

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= in_data;
    end

    // Next fill level from simultaneous push/pop
    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO pointers, level, registered full and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q <= level_d;
            full_q  <= (level_d == LVL_W'(FIFO_DEPTH));
            if (in_valid && full_q) overflow_q <= 1'b1;
        end
    end

    // Framing FSM: next state and next registered TX outputs
    always_comb begin
        state_d      = state_q;
        hdr_idx_d    = hdr_idx_q;
        word_d       = word_q;
        lane_d       = lane_q;
        gap_d        = gap_q;
        seq_d        = seq_q;
        frame_cnt_d  = frame_cnt_q;
        tx_data_d    = tx_data_q;
        tx_sof_d     = tx_sof_q;
        tx_eof_d     = tx_eof_q;
        tx_src_rdy_d = tx_src_rdy_q;
        pop          = 1'b0;
        start_frame  = 1'b0;

        unique case (state_q)
            IDLE: start_frame = frame_ready;
            HEAD: begin
                if (xfer) begin
                    tx_sof_d = 1'b0;
                    if (hdr_idx_q == 4'd15) begin
                        state_d   = DATA;
                        word_d    = '0;
                        lane_d    = '0;
                        tx_data_d = lane_byte(head_word, '0);
                        tx_eof_d  = (PAYLOAD_WORDS == 1) && (LANES == 1);
                    end else begin
                        hdr_idx_d = hdr_idx_q + 4'd1;
                        tx_data_d = hdr_byte(hdr_vec, hdr_idx_q + 4'd1);
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    if (lane_q == LANE_W'(LANES - 1)) begin
                        pop = 1'b1;
                        if (word_q == WORD_W'(PAYLOAD_WORDS - 1)) begin
                            state_d      = GAP;
                            gap_d        = '0;
                            frame_cnt_d  = frame_cnt_q + 16'd1;
                            tx_src_rdy_d = 1'b0;
                            tx_eof_d     = 1'b0;
                        end else begin
                            word_d    = word_q + WORD_W'(1);
                            lane_d    = '0;
                            tx_data_d = lane_byte(next_word, '0);
                            tx_eof_d  = (word_d == WORD_W'(PAYLOAD_WORDS - 1)) && (LANES == 1);
                        end
                    end else begin
                        lane_d    = lane_q + LANE_W'(1);
                        tx_data_d = lane_byte(head_word, lane_d);
                        tx_eof_d  = (word_q == WORD_W'(PAYLOAD_WORDS - 1)) &&
                                    (lane_d == LANE_W'(LANES - 1));
                    end
                end
            end
            GAP: begin
                // The final gap cycle also performs the idle check, so exactly
                // IFG_CYCLES dead cycles separate back-to-back frames.
                if (gap_q == GAP_W'(IFG_CYCLES - 1)) begin
                    if (frame_ready) start_frame = 1'b1;
                    else             state_d     = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_frame) begin
            state_d      = HEAD;
            hdr_idx_d    = '0;
            seq_d        = frame_cnt_q;
            tx_src_rdy_d = 1'b1;
            tx_sof_d     = 1'b1;
            tx_eof_d     = 1'b0;
            tx_data_d    = DST_MAC[47:40];
        end
    end

    // FSM state and TX output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hdr_idx_q    <= '0;
            word_q       <= '0;
            lane_q       <= '0;
            gap_q        <= '0;
            seq_q        <= '0;
            frame_cnt_q  <= '0;
            tx_data_q    <= '0;
            tx_sof_q     <= 1'b0;
            tx_eof_q     <= 1'b0;
            tx_src_rdy_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hdr_idx_q    <= hdr_idx_d;
            word_q       <= word_d;
            lane_q       <= lane_d;
            gap_q        <= gap_d;
            seq_q        <= seq_d;
            frame_cnt_q  <= frame_cnt_d;
            tx_data_q    <= tx_data_d;
            tx_sof_q     <= tx_sof_d;
            tx_eof_q     <= tx_eof_d;
            tx_src_rdy_q <= tx_src_rdy_d;
        end
    end

endmodule

// File: tb/tb_eth_frame_packer.sv
// Scoreboard bench for eth_frame_packer: default 32-bit instance plus a small
// 16-bit / 4-word / IFG=1 instance.
module tb_eth_frame_packer;

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eof;
    } beat_t;

    localparam int FRAME_BYTES = 1436;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  tx_data;
    logic        tx_sof, tx_eof, tx_src_rdy;
    logic        tx_dst_rdy = 1'b1;
    logic        overflow;
    logic [15:0] frame_cnt;
    logic [9:0]  fifo_level;

    logic [15:0] s_in_data = '0;
    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [7:0]  s_tx_data;
    logic        s_tx_sof, s_tx_eof, s_tx_src_rdy;
    logic        s_tx_dst_rdy = 1'b1;
    logic        s_overflow;
    logic [15:0] s_frame_cnt;
    logic [3:0]  s_fifo_level;

    int checks = 0;
    int failures = 0;
    int mode = 0;

    beat_t exp_q[$];
    beat_t s_q[$];
    beat_t e, se;

    int    eof_seen = 0, frame_bytes = 0, gap_cnt = 0, last_gap = -1;
    bit    gap_armed = 0, stall_prev = 0;
    logic [9:0] held;
    int    s_eof_seen = 0, s_frame_bytes = 0, s_gap_cnt = 0, s_last_gap = -1;
    bit    s_gap_armed = 0;

    eth_frame_packer u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .tx_data(tx_data), .tx_sof(tx_sof), .tx_eof(tx_eof),
        .tx_src_rdy(tx_src_rdy), .tx_dst_rdy(tx_dst_rdy),
        .overflow(overflow), .frame_cnt(frame_cnt), .fifo_level(fifo_level)
    );

    eth_frame_packer #(
        .DATA_W(16), .FIFO_DEPTH(8), .PAYLOAD_WORDS(4), .IFG_CYCLES(1)
    ) u_small (
        .clk(clk), .rst_n(rst_n),
        .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .tx_data(s_tx_data), .tx_sof(s_tx_sof), .tx_eof(s_tx_eof),
        .tx_src_rdy(s_tx_src_rdy), .tx_dst_rdy(s_tx_dst_rdy),
        .overflow(s_overflow), .frame_cnt(s_frame_cnt), .fifo_level(s_fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic logic [7:0] hdr_byte(input int i, input logic [15:0] seq);
        case (i)
            0: return 8'hDA;  1: return 8'h02;  2: return 8'h03;  3: return 8'h04;
            4: return 8'h05;  5: return 8'h06;  6: return 8'h00;  7: return 8'h2B;
            8: return 8'h67;  9: return 8'hBE; 10: return 8'hCE; 11: return 8'hAA;
           12: return 8'h08; 13: return 8'h00; 14: return seq[15:8];
            default: return seq[7:0];
        endcase
    endfunction

    // Expected 1436-byte frame for words base..base+354
    task automatic gen_frame(input logic [15:0] seq, input logic [31:0] base);
        beat_t b;
        logic [31:0] w;
        for (int i = 0; i < 16; i++) begin
            b.d = hdr_byte(i, seq); b.sof = (i == 0); b.eof = 1'b0;
            exp_q.push_back(b);
        end
        for (int k = 0; k < 355; k++) begin
            w = base + 32'(k);
            for (int l = 0; l < 4; l++) begin
                b.d = w[8*l +: 8]; b.sof = 1'b0; b.eof = (k == 354 && l == 3);
                exp_q.push_back(b);
            end
        end
    endtask

    // Expected 24-byte frame for the small instance; pay lists payload bytes in wire order
    task automatic gen_small(input logic [15:0] seq, input logic [63:0] pay);
        beat_t b;
        for (int i = 0; i < 16; i++) begin
            b.d = hdr_byte(i, seq); b.sof = (i == 0); b.eof = 1'b0;
            s_q.push_back(b);
        end
        for (int j = 0; j < 8; j++) begin
            b.d = pay[63-8*j -: 8]; b.sof = 1'b0; b.eof = (j == 7);
            s_q.push_back(b);
        end
    endtask

    // Push n words base+k starting at a negedge; optionally honour in_ready
    task automatic push_seq(input logic [31:0] base, input int n, input bit wait_rdy);
        int guard;
        for (int k = 0; k < n; k++) begin
            if (wait_rdy && !in_ready) begin
                in_valid = 1'b0;
                guard = 0;
                while (!in_ready && guard < 5000) begin
                    @(negedge clk);
                    guard++;
                end
                if (!in_ready) begin
                    checks++; failures++;
                    $display("FAIL in_ready_wait got=0 want=1");
                    break;
                end
            end
            in_data  = base + 32'(k);
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic push_small(input logic [15:0] w);
        s_in_data  = w;
        s_in_valid = 1'b1;
        @(negedge clk);
        s_in_valid = 1'b0;
    endtask

    task automatic wait_eofs(input int n, input int budget);
        int target = eof_seen + n;
        int c = 0;
        while (eof_seen < target && c < budget) begin
            @(posedge clk); #3;
            c++;
        end
        check("eof_wait", 64'(eof_seen), 64'(target));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tx_data"}, 64'(tx_data), 64'(0));
        check({tag, "_tx_sof"}, 64'(tx_sof), 64'(0));
        check({tag, "_tx_eof"}, 64'(tx_eof), 64'(0));
        check({tag, "_tx_src_rdy"}, 64'(tx_src_rdy), 64'(0));
        check({tag, "_overflow"}, 64'(overflow), 64'(0));
        check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(0));
        check({tag, "_fifo_level"}, 64'(fifo_level), 64'(0));
    endtask

    // Sink ready pattern: 0 = always ready, 1 = pseudo-random, 2 = stalled
    always @(posedge clk) begin
        #1;
        case (mode)
            0:       tx_dst_rdy = 1'b1;
            1:       tx_dst_rdy = 1'($urandom_range(0, 1));
            default: tx_dst_rdy = 1'b0;
        endcase
    end

    // Monitor for the default instance: scoreboard pop, stall hold, length, gap
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev  = 1'b0;
            gap_armed   = 1'b0;
            frame_bytes = 0;
        end else begin
            if (stall_prev)
                check("stall_hold", 64'({tx_src_rdy, tx_sof, tx_eof, tx_data}), 64'({1'b1, held}));
            if (gap_armed) begin
                if (tx_src_rdy) begin
                    last_gap  = gap_cnt;
                    gap_armed = 1'b0;
                end else begin
                    gap_cnt++;
                end
            end
            if (tx_src_rdy && tx_dst_rdy) begin
                frame_bytes = tx_sof ? 1 : frame_bytes + 1;
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_byte got=%h want=none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("byte%0d", frame_bytes - 1),
                          64'({tx_sof, tx_eof, tx_data}), 64'({e.sof, e.eof, e.d}));
                end
                if (tx_eof) begin
                    check("frame_len", 64'(frame_bytes), 64'(FRAME_BYTES));
                    eof_seen++;
                    gap_armed = 1'b1;
                    gap_cnt   = 0;
                end
            end
            stall_prev = tx_src_rdy && !tx_dst_rdy;
            held       = {tx_sof, tx_eof, tx_data};
        end
    end

    // Monitor for the small instance
    always @(negedge clk) begin
        if (!rst_n) begin
            s_gap_armed   = 1'b0;
            s_frame_bytes = 0;
        end else begin
            if (s_gap_armed) begin
                if (s_tx_src_rdy) begin
                    s_last_gap  = s_gap_cnt;
                    s_gap_armed = 1'b0;
                end else begin
                    s_gap_cnt++;
                end
            end
            if (s_tx_src_rdy && s_tx_dst_rdy) begin
                s_frame_bytes = s_tx_sof ? 1 : s_frame_bytes + 1;
                if (s_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL small_unexpected_byte got=%h want=none", s_tx_data);
                end else begin
                    se = s_q.pop_front();
                    check($sformatf("small_byte%0d", s_frame_bytes - 1),
                          64'({s_tx_sof, s_tx_eof, s_tx_data}), 64'({se.sof, se.eof, se.d}));
                end
                if (s_tx_eof) begin
                    check("small_frame_len", 64'(s_frame_bytes), 64'(24));
                    s_eof_seen++;
                    s_gap_armed = 1'b1;
                    s_gap_cnt   = 0;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        bit early;

        // Reset values
        repeat (3) @(posedge clk);
        #3 check_reset_vals("reset");
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", 64'(in_ready), 64'(1));

        // 1: one frame, words 1..0x163, sink always ready
        gen_frame(16'd0, 32'd1);
        push_seq(32'd1, 355, 1'b1);
        wait_eofs(1, 5000);
        check("t1_frame_cnt", 64'(frame_cnt), 64'(1));
        check("t1_queue_empty", 64'(exp_q.size()), 64'(0));

        // 2: random backpressure, seq 00 01
        mode = 1;
        gen_frame(16'd1, 32'hA5A50000);
        @(negedge clk);
        push_seq(32'hA5A50000, 355, 1'b1);
        wait_eofs(1, 10000);
        mode = 0;
        check("t2_frame_cnt", 64'(frame_cnt), 64'(2));
        check("t2_queue_empty", 64'(exp_q.size()), 64'(0));

        // 3: 710 words continuously, two frames with a 16-cycle gap
        gen_frame(16'd2, 32'h00010000);
        gen_frame(16'd3, 32'h00010000 + 32'd355);
        @(negedge clk);
        push_seq(32'h00010000, 710, 1'b1);
        wait_eofs(2, 10000);
        check("t3_gap", 64'(last_gap), 64'(16));
        check("t3_frame_cnt", 64'(frame_cnt), 64'(4));
        check("t3_queue_empty", 64'(exp_q.size()), 64'(0));
        check("t3_no_overflow", 64'(overflow), 64'(0));

        // 4: sink stalled, fill to 512, 513th word dropped
        mode = 2;
        repeat (3) @(negedge clk);
        push_seq(32'h00C00000, 512, 1'b0);
        check("t4_full_in_ready", 64'(in_ready), 64'(0));
        check("t4_full_level", 64'(fifo_level), 64'(512));
        in_data  = 32'hDEADBEEF;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("t4_overflow", 64'(overflow), 64'(1));
        check("t4_level_after_drop", 64'(fifo_level), 64'(512));
        gen_frame(16'd4, 32'h00C00000);
        gen_frame(16'd5, 32'h00C00000 + 32'd355);
        mode = 0;
        push_seq(32'h00C00000 + 32'd512, 198, 1'b1);
        wait_eofs(2, 10000);
        check("t4_overflow_sticky", 64'(overflow), 64'(1));
        check("t4_drained", 64'(fifo_level), 64'(0));
        check("t4_frame_cnt", 64'(frame_cnt), 64'(6));
        check("t4_queue_empty", 64'(exp_q.size()), 64'(0));

        // 5: reset in the middle of a frame
        gen_frame(16'd6, 32'h00500000);
        @(negedge clk);
        push_seq(32'h00500000, 355, 1'b1);
        c = 0;
        while (frame_bytes < 700 && c < 5000) begin
            @(posedge clk); #3;
            c++;
        end
        check("t5_reached_byte700", 64'(frame_bytes >= 700), 64'(1));
        rst_n = 1'b0;
        #1 check_reset_vals("midreset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_in_ready", 64'(in_ready), 64'(1));
        push_seq(32'h00600000, 354, 1'b1);
        early = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (tx_src_rdy) early = 1'b1;
        end
        check("t5_no_early_sof", 64'(early), 64'(0));
        gen_frame(16'd0, 32'h00600000);
        push_seq(32'h00600000 + 32'd354, 1, 1'b1);
        wait_eofs(1, 5000);
        check("t5_frame_cnt", 64'(frame_cnt), 64'(1));
        check("t5_queue_empty", 64'(exp_q.size()), 64'(0));

        // 6: small instance, 16-bit words, 4-word payload, IFG 1
        gen_small(16'd0, 64'hB2A1D4C3F6E51807);
        gen_small(16'd1, 64'h34127856BC9AF0DE);
        @(negedge clk);
        push_small(16'hA1B2);
        push_small(16'hC3D4);
        push_small(16'hE5F6);
        push_small(16'h0718);
        push_small(16'h1234);
        push_small(16'h5678);
        push_small(16'h9ABC);
        push_small(16'hDEF0);
        c = 0;
        while (s_eof_seen < 2 && c < 500) begin
            @(posedge clk); #3;
            c++;
        end
        check("t6_eofs", 64'(s_eof_seen), 64'(2));
        check("t6_gap", 64'(s_last_gap), 64'(1));
        check("t6_frame_cnt", 64'(s_frame_cnt), 64'(2));
        check("t6_queue_empty", 64'(s_q.size()), 64'(0));
        check("t6_no_overflow", 64'(s_overflow), 64'(0));

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
